// File: rtl/layer_sequencer_pkg.sv
// Shared types and default sizing for the layer sequencer.
// Optional feature macro: LAYER_SEQ_BIAS_EN (adds the BIAS state).
package layer_seq_pkg;

  localparam int unsigned N_IN_DEF  = 16;
  localparam int unsigned N_OUT_DEF = 4;
  localparam int unsigned IDX_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FEED,
`ifdef LAYER_SEQ_BIAS_EN
    S_BIAS,
`endif
    S_WRITE,
    S_DONE
  } state_t;

endpackage

// File: rtl/layer_sequencer_counter.sv
// Saturating up-counter used for the input and neuron indices.
// Counts 0..LIMIT-1 and holds at LIMIT-1; 'last' flags the terminal value.
module seq_counter
  import layer_seq_pkg::*;
#(
  parameter int unsigned WIDTH = IDX_W_DEF,
  parameter int unsigned LIMIT = N_IN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  assign last = (count == WIDTH'(LIMIT - 1));

  // Count register: clear has priority, enable advances until the terminal value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !last) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Layer pass sequencer: clears the accumulator, feeds N_IN operands per
// neuron (optionally followed by a bias slot), writes each of N_OUT results.
// Optional feature macro: LAYER_SEQ_BIAS_EN (BIAS state, ld with in_idx=N_IN).
module layer_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic             ld,
  output logic [IDX_W-1:0] in_idx,
  output logic [IDX_W-1:0] out_idx,
  output logic             acc_clr,
  output logic             wr_out,
  output logic             busy,
  output logic             ready
);

  state_t           state, state_nx;
  logic             hold;
  logic             feed_ld;
  logic             start_ok;
  logic             in_last, out_last;
  logic [IDX_W-1:0] in_cnt, out_cnt;

  // stall is registered into 'hold' so every output stays a pure function of
  // registered state: a stall sampled at an edge suppresses the next FEED load.
  assign feed_ld  = (state == S_FEED) && !hold;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));

  seq_counter #(.WIDTH(IDX_W), .LIMIT(N_IN)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == S_CLR),
    .en    (feed_ld),
    .count (in_cnt),
    .last  (in_last)
  );

  seq_counter #(.WIDTH(IDX_W), .LIMIT(N_OUT)) u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_ok),
    .en    (state == S_WRITE),
    .count (out_cnt),
    .last  (out_last)
  );

  // State and stall-hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      hold  <= 1'b0;
    end else begin
      state <= state_nx;
      hold  <= (state == S_FEED) && stall && !(feed_ld && in_last);
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    in_idx   = in_cnt;
    out_idx  = out_cnt;
    acc_clr  = 1'b0;
    wr_out   = 1'b0;
    busy     = 1'b1;
    ready    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_CLR;
      end
      S_CLR: begin
        acc_clr  = 1'b1;
        state_nx = S_FEED;
      end
      S_FEED: begin
        ld = feed_ld;
        if (feed_ld && in_last) begin
`ifdef LAYER_SEQ_BIAS_EN
          state_nx = S_BIAS;
`else
          state_nx = S_WRITE;
`endif
        end
      end
`ifdef LAYER_SEQ_BIAS_EN
      S_BIAS: begin
        ld       = 1'b1;
        in_idx   = IDX_W'(N_IN);
        state_nx = S_WRITE;
      end
`endif
      S_WRITE: begin
        wr_out   = 1'b1;
        state_nx = out_last ? S_DONE : S_CLR;
      end
      S_DONE: begin
        busy  = 1'b0;
        ready = 1'b1;
        if (start) state_nx = S_CLR;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
